// File: rtl/mult_pkg.sv
// mult_pkg: shared widths and the result flag bundle for the 8x8 multiplier pipe.
package mult_pkg;
  localparam int W  = 8;
  localparam int PW = 16;
  typedef struct packed {
    logic zero;
    logic ovf8;
  } flags_t;
endpackage

// File: rtl/mult_sign_cond.sv
// mult_sign_cond: operand magnitudes and product sign; -128 maps to 128, which still fits 8 unsigned bits.
module mult_sign_cond
  import mult_pkg::*;
(
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sgn_i,
  output logic [W-1:0] mag_a_o,
  output logic [W-1:0] mag_b_o,
  output logic         neg_o
);
  always_comb begin
    mag_a_o = (sgn_i && a_i[W-1]) ? W'(-a_i) : a_i;
    mag_b_o = (sgn_i && b_i[W-1]) ? W'(-b_i) : b_i;
    neg_o   = sgn_i & (a_i[W-1] ^ b_i[W-1]);
  end
endmodule

// File: rtl/multiplicador_8x8_recursivo.sv
// multiplicador_8x8_recursivo: combinational 8x8 unsigned multiplier built from four 4x4 partial products.
module multiplicador_8x8_recursivo (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);
  function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
    mul4 = {4'b0, x} * {4'b0, y};
  endfunction
  always_comb
    p_o = {8'b0, mul4(a_i[3:0], b_i[3:0])}
        + ({8'b0, mul4(a_i[7:4], b_i[3:0])} << 4)
        + ({8'b0, mul4(a_i[3:0], b_i[7:4])} << 4)
        + {mul4(a_i[7:4], b_i[7:4]), 8'b0};
endmodule

// File: rtl/mult_8x8_pipe.sv
// mult_8x8_pipe: two-stage valid/ready pipeline around the unsigned core with signed/unsigned products and flags.
module mult_8x8_pipe
  import mult_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [W-1:0]  a_i,
  input  logic [W-1:0]  b_i,
  input  logic          sgn_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [PW-1:0] p_o,
  output logic          zero_o,
  output logic          ovf8_o
);
  logic [W-1:0]  mag_a_d, mag_b_d, mag_a_q, mag_b_q;
  logic          neg_d, neg_q, sgn_q, s1_valid_q, out_valid_q, s2_adv;
  logic [PW-1:0] m, p_d, p_q;
  flags_t        flags_d, flags_q;
  mult_sign_cond u_sign (
    .a_i(a_i), .b_i(b_i), .sgn_i(sgn_i),
    .mag_a_o(mag_a_d), .mag_b_o(mag_b_d), .neg_o(neg_d)
  );
  multiplicador_8x8_recursivo u_core (.a_i(mag_a_q), .b_i(mag_b_q), .p_o(m));
  always_comb begin
    s2_adv       = !out_valid_q || out_ready_i;
    in_ready_o   = !s1_valid_q || s2_adv;
    p_d          = neg_q ? PW'(~m + 1'b1) : m;
    flags_d.zero = p_d == '0;
    flags_d.ovf8 = sgn_q ? (p_d[PW-1:W-1] != '0 && p_d[PW-1:W-1] != '1) : p_d[PW-1:W] != '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      neg_q       <= 1'b0;
      sgn_q       <= 1'b0;
      out_valid_q <= 1'b0;
      p_q         <= '0;
      flags_q     <= '0;
    end else begin
      if (in_valid_i && in_ready_o) begin
        s1_valid_q <= 1'b1;
        mag_a_q    <= mag_a_d;
        mag_b_q    <= mag_b_d;
        neg_q      <= neg_d;
        sgn_q      <= sgn_i;
      end else if (s2_adv) s1_valid_q <= 1'b0;
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          p_q     <= p_d;
          flags_q <= flags_d;
        end
      end
    end
  assign out_valid_o = out_valid_q;
  assign p_o         = p_q;
  assign zero_o      = flags_q.zero;
  assign ovf8_o      = flags_q.ovf8;
endmodule

// File: tb/tb_mult_8x8_pipe.sv
// tb_mult_8x8_pipe: directed and random checks of the pipelined multiplier against hand values and a scoreboard.
module tb_mult_8x8_pipe;
  logic        clk = 0, rst_n = 0, in_valid = 0, sgn = 0, out_ready = 0;
  logic        in_ready, out_valid, zero, ovf8;
  logic [7:0]  a = 0, b = 0;
  logic [15:0] p;
  int          checks = 0, errors = 0;
  mult_8x8_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .sgn_i(sgn), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .p_o(p), .zero_o(zero), .ovf8_o(ovf8)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_check(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                            input logic ts, input logic [15:0] ep, input logic ez, input logic eo);
    @(negedge clk); a = ta; b = tb; sgn = ts; in_valid = 1; #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk); in_valid = 0; #1;
    chk({tag, "_lat1"}, out_valid, 0);
    @(negedge clk); #1;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_p"}, p, ep);
    chk({tag, "_zero"}, zero, ez);
    chk({tag, "_ovf8"}, ovf8, eo);
  endtask
  logic [17:0] q[$];
  logic [17:0] exp_e;
  int sent, rcvd, cyc, sa, sb, prod;
  logic acc;
  initial begin
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_p", p, 0);
    chk("rst_zero", zero, 0);
    chk("rst_ovf8", ovf8, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1; out_ready = 1;
    send_check("u3x5", 8'd3, 8'd5, 0, 16'h000F, 0, 0);
    send_check("u255sq", 8'hFF, 8'hFF, 0, 16'hFE01, 0, 1);
    send_check("sm3x5", 8'hFD, 8'd5, 1, 16'hFFF1, 0, 0);
    send_check("s80x80", 8'h80, 8'h80, 1, 16'h4000, 0, 1);
    send_check("s80x1", 8'h80, 8'h01, 1, 16'hFF80, 0, 0);
    send_check("szero", 8'h00, 8'hC7, 1, 16'h0000, 1, 0);
    // backpressure: two pairs fill the pipe, third waits
    @(negedge clk); out_ready = 0; a = 2; b = 2; sgn = 0; in_valid = 1; #1;
    chk("bp_ready1", in_ready, 1);
    @(negedge clk); a = 3; b = 3; #1;
    chk("bp_ready2", in_ready, 1);
    chk("bp_valid_early", out_valid, 0);
    @(negedge clk); a = 4; b = 4; #1;
    chk("bp_ready_full", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_p4_a", p, 4);
    @(negedge clk); #1;
    chk("bp_ready_stall", in_ready, 0);
    chk("bp_p4_hold", p, 4);
    @(negedge clk); out_ready = 1; #1;
    chk("bp_ready_drain", in_ready, 1);
    chk("bp_p4", p, 4);
    @(negedge clk); in_valid = 0; #1;
    chk("bp_valid9", out_valid, 1);
    chk("bp_p9", p, 9);
    @(negedge clk); #1;
    chk("bp_valid16", out_valid, 1);
    chk("bp_p16", p, 16);
    @(negedge clk); #1;
    chk("bp_empty", out_valid, 0);
    // random streaming against a scoreboard
    sent = 0; rcvd = 0; cyc = 0;
    while ((sent < 256 || rcvd < 256) && cyc < 6000) begin
      @(negedge clk); cyc++;
      if (!in_valid && sent < 256 && $urandom_range(0, 3) != 0) begin
        a = 8'($urandom); b = 8'($urandom); sgn = 1'($urandom); in_valid = 1;
      end
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      if (out_valid && out_ready) begin
        chk("st_nodup", q.size() != 0, 1);
        if (q.size() != 0) begin
          exp_e = q.pop_front();
          chk("st_p", p, exp_e[17:2]);
          chk("st_zero", zero, exp_e[1]);
          chk("st_ovf8", ovf8, exp_e[0]);
        end
        rcvd++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        sa = sgn ? int'($signed(a)) : int'(a);
        sb = sgn ? int'($signed(b)) : int'(b);
        prod = sa * sb;
        q.push_back({prod[15:0], prod == 0, sgn ? (prod < -128 || prod > 127) : prod > 255});
        sent++;
      end
      @(posedge clk); #1;
      if (acc) in_valid = 0;
    end
    chk("st_rcvd", rcvd, 256);
    chk("st_sent", sent, 256);
    // asynchronous reset with two pairs in flight
    @(negedge clk); out_ready = 0; a = 5; b = 5; sgn = 0; in_valid = 1;
    @(negedge clk); a = 6; b = 6;
    @(negedge clk); in_valid = 0; #1;
    chk("rs_pre_valid", out_valid, 1);
    #2 rst_n = 0; #1;
    chk("rs_valid", out_valid, 0);
    chk("rs_p", p, 0);
    chk("rs_zero", zero, 0);
    chk("rs_ovf8", ovf8, 0);
    @(negedge clk); rst_n = 1; #1;
    chk("rs_in_ready", in_ready, 1);
    out_ready = 1;
    repeat (4) begin
      @(negedge clk); #1;
      chk("rs_no_stale", out_valid, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
